// File: rtl/schmidl_cox_pkg.sv
// Shared types and helpers for the Schmidl-Cox timing-metric datapath.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package schmidl_cox_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  // One quotient bit per iteration, so the iteration count equals the quotient width.
  function automatic int div_iters(input int width, input int frac_bits);
    return width + frac_bits;
  endfunction

endpackage

// File: rtl/div_restoring_step.sv
// One restoring-division iteration: shift a dividend bit into the partial remainder, conditionally subtract.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is registered.
module div_restoring_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] den_i,
  input  logic             in_bit_i,
  output logic [WIDTH-1:0] rem_next_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] trial;

  // Compare at WIDTH+1 bits so the shifted-out remainder MSB is never lost.
  // rem_i < den_i always holds, so trial - den fits back into WIDTH bits and a
  // WIDTH-bit subtraction gives the exact new remainder.
  always_comb begin
    trial      = {rem_i, in_bit_i};
    rem_next_o = trial[WIDTH-1:0];
    q_bit_o    = 1'b0;
    if (trial >= {1'b0, den_i}) begin
      rem_next_o = trial[WIDTH-1:0] - den_i;
      q_bit_o    = 1'b1;
    end
  end

endmodule

// File: rtl/axis_seq_divider.sv
// Iterative restoring fixed-point divider: quot = (num << FRAC_BITS) / den plus remainder, one bit per clk.
// Latency: result valid N clk after the joint operand accept (1 clk for a zero divisor).
// Backpressure: operands accepted only together and only when idle; result held without limit until o_tready.
module axis_seq_divider
  import schmidl_cox_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int FRAC_BITS = 16
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   clear,
  input  logic [WIDTH-1:0]                       num_tdata,
  input  logic                                   num_tlast,
  input  logic                                   num_tvalid,
  output logic                                   num_tready,
  input  logic [WIDTH-1:0]                       den_tdata,
  input  logic                                   den_tlast,
  input  logic                                   den_tvalid,
  output logic                                   den_tready,
  output logic [div_iters(WIDTH, FRAC_BITS)-1:0] o_quot_tdata,
  output logic [WIDTH-1:0]                       o_rem_tdata,
  output logic                                   o_div0,
  output logic                                   o_tlast,
  output logic                                   o_tvalid,
  input  logic                                   o_tready
);

  localparam int N  = div_iters(WIDTH, FRAC_BITS);
  localparam int CW = $clog2(N + 1);

  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(N);

  div_state_t     state_q, state_d;
  logic [N-1:0]     shift_q, shift_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] den_q, den_d;
  logic             tlast_q, tlast_d;
  logic             div0_q, div0_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             accept;
  logic             done;
  logic [WIDTH-1:0] step_rem;
  logic             step_qbit;

  // The divisor's own tlast carries no information; packet framing follows the dividend.
  logic unused_den_tlast;
  assign unused_den_tlast = den_tlast;

  // Join: both operands must be valid together; nothing is taken during reset/clear.
  assign accept     = (state_q == DIV_IDLE) && num_tvalid && den_tvalid && !reset && !clear;
  assign num_tready = accept;
  assign den_tready = accept;

  div_restoring_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_i      (rem_q),
    .den_i      (den_q),
    .in_bit_i   (shift_q[N-1]),
    .rem_next_o (step_rem),
    .q_bit_o    (step_qbit)
  );

  // Next-state logic: load on accept, one quotient bit per CALC cycle, hold in DONE.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    rem_d   = rem_q;
    den_d   = den_q;
    tlast_d = tlast_q;
    div0_d  = div0_q;
    cnt_d   = cnt_q;

    case (state_q)
      DIV_IDLE: begin
        if (accept) begin
          den_d   = den_tdata;
          tlast_d = num_tlast;
          cnt_d   = '0;
          state_d = DIV_CALC;
          if (den_tdata == '0) begin
            // Saturated result is loaded up front; the single CALC cycle then
            // just publishes it, giving the one-clock zero-divisor latency.
            div0_d  = 1'b1;
            shift_d = '1;
            rem_d   = num_tdata;
          end else begin
            div0_d  = 1'b0;
            shift_d = {num_tdata, {FRAC_BITS{1'b0}}};
            rem_d   = '0;
          end
        end
      end

      DIV_CALC: begin
        if (div0_q) begin
          state_d = DIV_DONE;
        end else begin
          // Dividend bits leave at the top of shift_q while quotient bits enter at the bottom.
          shift_d = {shift_q[N-2:0], step_qbit};
          rem_d   = step_rem;
          cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = DIV_DONE;
          end
        end
      end

      DIV_DONE: begin
        if (o_tready) begin
          state_d = DIV_IDLE;
        end
      end

      default: begin
        state_d = DIV_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset and clear both discard any operation in flight.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_q <= DIV_IDLE;
      shift_q <= '0;
      rem_q   <= '0;
      den_q   <= '0;
      tlast_q <= 1'b0;
      div0_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      rem_q   <= rem_d;
      den_q   <= den_d;
      tlast_q <= tlast_d;
      div0_q  <= div0_d;
      cnt_q   <= cnt_d;
    end
  end

  // Results are only exposed in DONE, so intermediate CALC values never leak downstream.
  assign done         = (state_q == DIV_DONE);
  assign o_tvalid     = done;
  assign o_quot_tdata = done ? shift_q : '0;
  assign o_rem_tdata  = done ? rem_q : '0;
  assign o_div0       = done & div0_q;
  assign o_tlast      = done & tlast_q;

endmodule

// File: tb/tb_axis_seq_divider.sv
// Self-checking bench for axis_seq_divider at WIDTH=8, FRAC_BITS=4 (N=12).
// Latency: directed tests measure result latency in clock edges after the accept edge.
// Backpressure: exercised with stalled o_tready and randomized valids/ready.
module tb_axis_seq_divider;

  localparam int W  = 8;
  localparam int F  = 4;
  localparam int NQ = W + F;

  logic          clk = 1'b0;
  logic          reset;
  logic          clear;
  logic [W-1:0]  num_tdata;
  logic          num_tlast;
  logic          num_tvalid;
  logic          num_tready;
  logic [W-1:0]  den_tdata;
  logic          den_tlast;
  logic          den_tvalid;
  logic          den_tready;
  logic [NQ-1:0] o_quot_tdata;
  logic [W-1:0]  o_rem_tdata;
  logic          o_div0;
  logic          o_tlast;
  logic          o_tvalid;
  logic          o_tready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axis_seq_divider #(
    .WIDTH     (W),
    .FRAC_BITS (F)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .clear        (clear),
    .num_tdata    (num_tdata),
    .num_tlast    (num_tlast),
    .num_tvalid   (num_tvalid),
    .num_tready   (num_tready),
    .den_tdata    (den_tdata),
    .den_tlast    (den_tlast),
    .den_tvalid   (den_tvalid),
    .den_tready   (den_tready),
    .o_quot_tdata (o_quot_tdata),
    .o_rem_tdata  (o_rem_tdata),
    .o_div0       (o_div0),
    .o_tlast      (o_tlast),
    .o_tvalid     (o_tvalid),
    .o_tready     (o_tready)
  );

  // Reference: plain integer fixed-point division, saturated on a zero divisor.
  function automatic logic [NQ-1:0] ref_quot(input int n, input int d);
    if (d == 0) return '1;
    return NQ'((n * (1 << F)) / d);
  endfunction

  function automatic logic [W-1:0] ref_rem(input int n, input int d);
    if (d == 0) return W'(n);
    return W'((n * (1 << F)) % d);
  endfunction

  // Drives one operand pair, waits for the result and consumes it. Latency counts
  // clock edges after the accept edge until o_tvalid is seen.
  task automatic run_op(input int n, input int d, input logic tl, output int lat,
                        output logic [NQ-1:0] q, output logic [W-1:0] r,
                        output logic d0, output logic tlo, output logic ok);
    logic acc;
    logic got;
    ok = 1'b1; acc = 1'b0; got = 1'b0; lat = 0;
    q = '0; r = '0; d0 = 1'b0; tlo = 1'b0;
    @(posedge clk); #1;
    num_tdata = W'(n); den_tdata = W'(d); num_tlast = tl;
    num_tvalid = 1'b1; den_tvalid = 1'b1;
    for (int c = 0; c < 50 && !acc; c++) begin
      @(negedge clk);
      if (num_tready) acc = 1'b1;
    end
    @(posedge clk); #1;
    num_tvalid = 1'b0; den_tvalid = 1'b0;
    if (!acc) begin
      ok = 1'b0;
      return;
    end
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge clk);
      if (o_tvalid) got = 1'b1;
      else lat++;
    end
    if (!got) begin
      ok = 1'b0;
      return;
    end
    q = o_quot_tdata; r = o_rem_tdata; d0 = o_div0; tlo = o_tlast;
    @(posedge clk); #1;
    o_tready = 1'b1;
    @(posedge clk); #1;
    o_tready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    num_tvalid = 1'b1; den_tvalid = 1'b1; num_tdata = 8'd10; den_tdata = 8'd3;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (num_tready !== 1'b0 || den_tready !== 1'b0) begin errors++; $display("FAIL reset_readies: got %b%b expected 00", num_tready, den_tready); end
    checks++; if (o_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b expected 0", o_tvalid); end
    checks++; if (o_quot_tdata !== '0 || o_rem_tdata !== '0) begin errors++; $display("FAIL reset_data: got q=%h r=%h expected 0/0", o_quot_tdata, o_rem_tdata); end
    checks++; if (o_div0 !== 1'b0 || o_tlast !== 1'b0) begin errors++; $display("FAIL reset_flags: got div0=%b tlast=%b expected 0/0", o_div0, o_tlast); end
    @(posedge clk); #1;
    num_tvalid = 1'b0; den_tvalid = 1'b0; reset = 1'b0;
  endtask

  task automatic test_basic();
    int lat; logic [NQ-1:0] q; logic [W-1:0] r; logic d0, tl, ok;
    run_op(100, 7, 1'b1, lat, q, r, d0, tl, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout: got no result expected result"); end
    checks++; if (lat !== 12) begin errors++; $display("FAIL basic_latency: got %0d expected 12", lat); end
    checks++; if (q !== 12'h0E4) begin errors++; $display("FAIL basic_quot: got %h expected 0e4", q); end
    checks++; if (r !== 8'd4) begin errors++; $display("FAIL basic_rem: got %0d expected 4", r); end
    checks++; if (d0 !== 1'b0 || tl !== 1'b1) begin errors++; $display("FAIL basic_flags: got div0=%b tlast=%b expected 0/1", d0, tl); end
  endtask

  task automatic test_div0();
    int lat; logic [NQ-1:0] q; logic [W-1:0] r; logic d0, tl, ok;
    run_op(55, 0, 1'b0, lat, q, r, d0, tl, ok);
    checks++; if (!ok) begin errors++; $display("FAIL div0_timeout: got no result expected result"); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL div0_latency: got %0d expected 1", lat); end
    checks++; if (q !== 12'hFFF) begin errors++; $display("FAIL div0_quot: got %h expected fff", q); end
    checks++; if (r !== 8'd55) begin errors++; $display("FAIL div0_rem: got %0d expected 55", r); end
    checks++; if (d0 !== 1'b1 || tl !== 1'b0) begin errors++; $display("FAIL div0_flags: got div0=%b tlast=%b expected 1/0", d0, tl); end
  endtask

  task automatic test_extremes();
    int            en[3] = '{255, 0, 1};
    int            ed[3] = '{1, 9, 255};
    logic [NQ-1:0] eq[3] = '{12'hFF0, 12'h000, 12'h000};
    logic [W-1:0]  er[3] = '{8'd0, 8'd0, 8'd16};
    int lat; logic [NQ-1:0] q; logic [W-1:0] r; logic d0, tl, ok;
    for (int i = 0; i < 3; i++) begin
      run_op(en[i], ed[i], 1'b0, lat, q, r, d0, tl, ok);
      checks++; if (!ok || lat !== 12) begin errors++; $display("FAIL extreme%0d_latency: got ok=%b lat=%0d expected 1/12", i, ok, lat); end
      checks++; if (q !== eq[i] || r !== er[i] || d0 !== 1'b0) begin errors++; $display("FAIL extreme%0d_result: got q=%h r=%0d div0=%b expected q=%h r=%0d div0=0", i, q, r, d0, eq[i], er[i]); end
    end
  endtask

  task automatic test_join_backpressure();
    int   extra_acc = 0;
    int   unstable = 0;
    logic got = 1'b0;
    @(posedge clk); #1;
    num_tdata = 8'd42; den_tdata = 8'd5; num_tlast = 1'b1;
    num_tvalid = 1'b1; den_tvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (num_tready !== 1'b0 || den_tready !== 1'b0) begin errors++; $display("FAIL join_half_valid%0d: got readies %b%b expected 00", i, num_tready, den_tready); end
    end
    @(posedge clk); #1;
    den_tvalid = 1'b1;
    @(negedge clk);
    checks++; if (num_tready !== 1'b1 || den_tready !== 1'b1) begin errors++; $display("FAIL join_accept: got readies %b%b expected 11", num_tready, den_tready); end
    @(posedge clk); #1;
    num_tdata = 8'd77; den_tdata = 8'd4; num_tlast = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      if (num_tready || den_tready) extra_acc++;
      if (o_tvalid) got = 1'b1;
    end
    checks++; if (!got || extra_acc !== 0) begin errors++; $display("FAIL join_single_accept: got result=%b extra accepts=%0d expected 1/0", got, extra_acc); end
    for (int i = 0; i < 10; i++) begin
      if (o_tvalid !== 1'b1 || o_quot_tdata !== 12'h086 || o_rem_tdata !== 8'd2 ||
          o_div0 !== 1'b0 || o_tlast !== 1'b1 || num_tready || den_tready) unstable++;
      @(negedge clk);
    end
    checks++; if (unstable !== 0) begin errors++; $display("FAIL stall_stable: got %0d bad cycles expected 0 (last q=%h r=%0d)", unstable, o_quot_tdata, o_rem_tdata); end
    @(posedge clk); #1;
    num_tvalid = 1'b0; den_tvalid = 1'b0; o_tready = 1'b1;
    @(posedge clk); #1;
    o_tready = 1'b0;
    @(negedge clk);
    checks++; if (o_tvalid !== 1'b0) begin errors++; $display("FAIL stall_release: got tvalid=%b expected 0", o_tvalid); end
  endtask

  task automatic test_reset_mid_calc(input logic use_clear);
    logic acc = 1'b0;
    int   stray = 0;
    int lat; logic [NQ-1:0] q; logic [W-1:0] r; logic d0, tl, ok;
    @(posedge clk); #1;
    num_tdata = 8'd100; den_tdata = 8'd7; num_tlast = 1'b1;
    num_tvalid = 1'b1; den_tvalid = 1'b1;
    for (int c = 0; c < 50 && !acc; c++) begin
      @(negedge clk);
      if (num_tready) acc = 1'b1;
    end
    @(posedge clk); #1;
    num_tvalid = 1'b0; den_tvalid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    if (use_clear) clear = 1'b1; else reset = 1'b1;
    num_tdata = 8'd9; den_tdata = 8'd9; num_tvalid = 1'b1; den_tvalid = 1'b1;
    @(negedge clk);
    checks++; if (!acc || num_tready !== 1'b0 || den_tready !== 1'b0) begin errors++; $display("FAIL flush%0d_readies: got started=%b readies %b%b expected 1/00", use_clear, acc, num_tready, den_tready); end
    @(posedge clk); #1;
    reset = 1'b0; clear = 1'b0; num_tvalid = 1'b0; den_tvalid = 1'b0;
    @(negedge clk);
    checks++; if (o_tvalid !== 1'b0 || o_quot_tdata !== '0 || o_rem_tdata !== '0 || o_div0 !== 1'b0 || o_tlast !== 1'b0) begin errors++; $display("FAIL flush%0d_outputs: got v=%b q=%h r=%h d0=%b tl=%b expected all 0", use_clear, o_tvalid, o_quot_tdata, o_rem_tdata, o_div0, o_tlast); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_tvalid) stray++;
    end
    checks++; if (stray !== 0) begin errors++; $display("FAIL flush%0d_discard: got %0d stray valid cycles expected 0", use_clear, stray); end
    run_op(200, 3, 1'b0, lat, q, r, d0, tl, ok);
    checks++; if (!ok || lat !== 12) begin errors++; $display("FAIL flush%0d_next_latency: got ok=%b lat=%0d expected 1/12", use_clear, ok, lat); end
    checks++; if (q !== 12'h42A || r !== 8'd2 || d0 !== 1'b0 || tl !== 1'b0) begin errors++; $display("FAIL flush%0d_next_result: got q=%h r=%0d d0=%b tl=%b expected 42a/2/0/0", use_clear, q, r, d0, tl); end
  endtask

  task automatic test_stream();
    logic [NQ-1:0] exp_q[$];
    logic [W-1:0]  exp_r[$];
    logic          exp_d0[$];
    logic          exp_tl[$];
    int sent = 0, got = 0, tlast_seen = 0, join_bad = 0, prod_stuck = 0;
    num_tvalid = 1'b0; den_tvalid = 1'b0;
    fork
      begin
        for (int i = 0; i < 64; i++) begin
          int   n, d, tries;
          logic acc;
          n = $urandom_range(0, 255);
          d = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 255);
          num_tdata = W'(n); den_tdata = W'(d); num_tlast = (i % 8 == 7);
          acc = 1'b0; tries = 0;
          while (!acc && tries < 3000) begin
            if (!num_tvalid) num_tvalid = ($urandom_range(0, 2) != 0);
            if (!den_tvalid) den_tvalid = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (num_tready !== den_tready) join_bad++;
            if ((num_tvalid !== den_tvalid) && num_tready) join_bad++;
            if (num_tready && num_tvalid && den_tvalid) begin
              acc = 1'b1;
              exp_q.push_back(ref_quot(n, d));
              exp_r.push_back(ref_rem(n, d));
              exp_d0.push_back(d == 0);
              exp_tl.push_back(i % 8 == 7);
              sent++;
            end
            @(posedge clk); #1;
            if (acc) begin num_tvalid = 1'b0; den_tvalid = 1'b0; end
            tries++;
          end
          if (!acc) prod_stuck++;
        end
      end
      begin
        int cyc = 0;
        while (got < 64 && cyc < 20000) begin
          @(posedge clk); #1;
          o_tready = $urandom_range(0, 1);
          @(negedge clk);
          cyc++;
          if (o_tvalid && o_tready) begin
            if (exp_q.size() == 0) begin
              checks++; errors++; $display("FAIL stream_dup: got result q=%h with nothing outstanding expected none", o_quot_tdata);
            end else begin
              logic [NQ-1:0] eq; logic [W-1:0] er; logic ed, et;
              eq = exp_q.pop_front(); er = exp_r.pop_front(); ed = exp_d0.pop_front(); et = exp_tl.pop_front();
              checks++; if (o_quot_tdata !== eq) begin errors++; $display("FAIL stream_quot%0d: got %h expected %h", got, o_quot_tdata, eq); end
              checks++; if (o_rem_tdata !== er) begin errors++; $display("FAIL stream_rem%0d: got %0d expected %0d", got, o_rem_tdata, er); end
              checks++; if (o_div0 !== ed) begin errors++; $display("FAIL stream_div0_%0d: got %b expected %b", got, o_div0, ed); end
              checks++; if (o_tlast !== et) begin errors++; $display("FAIL stream_tlast%0d: got %b expected %b", got, o_tlast, et); end
            end
            if (o_tlast) tlast_seen++;
            got++;
          end
        end
        @(posedge clk); #1;
        o_tready = 1'b0;
      end
    join
    checks++; if (got !== 64 || sent !== 64 || prod_stuck !== 0) begin errors++; $display("FAIL stream_count: got %0d results from %0d sent (%0d stuck) expected 64/64/0", got, sent, prod_stuck); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL stream_leftover: got %0d outstanding expected 0", exp_q.size()); end
    checks++; if (tlast_seen !== 8) begin errors++; $display("FAIL stream_tlast_count: got %0d expected 8", tlast_seen); end
    checks++; if (join_bad !== 0) begin errors++; $display("FAIL stream_join: got %0d bad ready cycles expected 0", join_bad); end
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0;
    num_tdata = '0; num_tlast = 1'b0; num_tvalid = 1'b0;
    den_tdata = '0; den_tlast = 1'b0; den_tvalid = 1'b0;
    o_tready = 1'b0;
    test_reset();
    test_basic();
    test_div0();
    test_extremes();
    test_join_backpressure();
    test_reset_mid_calc(1'b0);
    test_reset_mid_calc(1'b1);
    test_stream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
